fp_divmod_seq: RTL and testbench
================================

// Module: fp_divmod_seq
// PURPOSE
//  Iterative signed fixed-point divider for the ray-marching datapath; completes the
//  arithmetic package's missing division and floored modulo (domain repetition).
//  Parametrised Q(WHOLE.FRAC) format, one quotient bit per cycle, valid/ready on
//  both sides. Sits beside the combinational add/mul helpers in the SDF evaluator.
// PARAMETERS
//  WHOLE   16  integer bits incl. sign (two's complement)
//  FRAC    16  fractional bits; W = WHOLE+FRAC, N = W+FRAC iterations
// PORTS
//  clk_in     in   1  clock
//  rst_in     in   1  asynchronous, active-high reset
//  in_valid   in   1  operands a_in/b_in valid
//  in_ready   out  1  divider can accept (IDLE only)
//  a_in       in   W  dividend, signed fixed point
//  b_in       in   W  divisor, signed fixed point
//  out_valid  out  1  results valid; held until out_ready
//  out_ready  in   1  consumer accepts results
//  quot_out   out  W  a/b, fixed point, truncated toward zero
//  mod_out    out  W  a - b*floor(a/b) (sign follows b), fixed point
//  div0_out   out  1  b_in was zero
//  ovf_out    out  1  |quotient| not representable in W bits
//  busy_out   out  1  state != IDLE
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE, in_ready=1, out_valid=0, quot/mod=0,
//    flags=0, busy=0; in-flight operation discarded, no result emitted.
//  - FSM: IDLE -> DIV -> FIX -> DONE -> IDLE.
//    IDLE: in_ready=1; on in_valid&&in_ready latch sa=sign(a), sb=sign(b), |a|,|b|
//      (W+1-bit magnitudes, so -2^(W-1) is exact); b==0 -> FIX directly, else DIV.
//    DIV: restoring long division of dividend {|a|, FRAC'b0} (N bits, MSB first) by |b|;
//      counter N-1..0, one quotient bit/cycle; remainder reg W+1 bits.
//      After exactly W bits shifted in, snapshot partial remainder = |a| mod |b|.
//    FIX (1 cycle): q = sa^sb ? -qmag : qmag; ovf if qmag > 2^(W-1)-1 (or > 2^(W-1)
//      when negative). r = sa ? -snap : snap; if r!=0 && sa!=sb then mod = r + b else r.
//    DONE: out_valid=1, outputs stable; out_ready -> IDLE next cycle (no same-cycle
//      re-accept; in_ready=0 in DONE).
//  - Latency: accept edge at cycle 0 -> out_valid high at cycle N+2 (b!=0), cycle 2 (b==0).
//  - Throughput: one op per N+3 cycles with out_ready tied high.
//  - Div-by-zero (no macro): quot_out=0, mod_out=a_in, div0_out=1, ovf_out=0.
//  - Overflow (no macro): quot_out = low W bits of signed quotient (wrap), ovf_out=1.
//  - Operand inputs ignored outside IDLE; changing a_in/b_in mid-DIV has no effect.
//  - mod_out never overflows (|mod| < |b|); b == most-negative value handled exactly.
// CONFIGURATION
//  FP_DIV_SAT_EN defined: overflow clamps quot_out to 2^(W-1)-1 (positive) or
//    -2^(W-1) (negative); div-by-zero gives 2^(W-1)-1 if a>=0 else -2^(W-1),
//    mod_out=0; div0_out/ovf_out still reported. Latency unchanged.
//  FP_DIV_SAT_EN undefined: wrap / zero behaviour as above.
// TESTING (WHOLE=16, FRAC=16, N=48)
//  a=0x00060000 (6.0), b=0x00040000 (4.0) -> quot 0x00018000, mod 0x00020000,
//    out_valid exactly 50 cycles after accept.
//  a=0xFFFA8000 (-5.5), b=0x00020000 (2.0) -> quot 0xFFFD4000 (-2.75), mod 0x00008000
//    (0.5); a=+5.5 same b -> mod 0x00018000 (1.5).
//  a=0x75300000 (30000.0), b=0x00008000 (0.5) -> ovf_out=1; quot 0x7FFFFFFF with
//    FP_DIV_SAT_EN, 0xEA600000 without.
//  b=0, a=0xFFFF0000 -> div0_out=1, out_valid at cycle 2; quot 0x80000000/mod 0 (SAT)
//    or quot 0/mod 0xFFFF0000 (no SAT).
//  out_ready low 10 cycles in DONE -> outputs/out_valid stable, in_ready=0; rst_in
//    pulsed mid-DIV -> IDLE, out_valid never rises, next op correct.

Source files
------------

// File: rtl/fp_divmod_seq.sv
// fp_divmod_seq
//   Iterative signed fixed-point divider with floored modulo for the SDF
//   evaluator. Operands are Q(WHOLE.FRAC) two's complement, W = WHOLE+FRAC.
//   The divider produces one quotient bit per cycle over N = W+FRAC cycles and
//   has a valid/ready handshake on both the input and output side.
//
// Ports
//   clk_in     clock
//   rst_in     asynchronous active-high reset
//   in_valid   a_in/b_in valid
//   in_ready   divider can accept (IDLE only)
//   a_in       dividend, signed fixed point
//   b_in       divisor, signed fixed point
//   out_valid  results valid, held until out_ready
//   out_ready  consumer accepts results
//   quot_out   a/b, truncated toward zero
//   mod_out    a - b*floor(a/b), sign follows b
//   div0_out   divisor was zero
//   ovf_out    quotient magnitude not representable in W bits
//   busy_out   operation in progress (state != IDLE)
//
// Configuration
//   FP_DIV_SAT_EN  defined: saturate quotient on overflow and divide-by-zero,
//                  mod_out = 0 on divide-by-zero.
//                  undefined: quotient wraps, divide-by-zero gives quot 0 and
//                  mod = a.
module fp_divmod_seq #(
   parameter int WHOLE = 16,
   parameter int FRAC  = 16
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [WHOLE+FRAC-1:0] a_in,
   input  logic [WHOLE+FRAC-1:0] b_in,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [WHOLE+FRAC-1:0] quot_out,
   output logic [WHOLE+FRAC-1:0] mod_out,
   output logic                  div0_out,
   output logic                  ovf_out,
   output logic                  busy_out
);

   localparam int W  = WHOLE + FRAC;
   localparam int N  = W + FRAC;
   localparam int CW = $clog2(N);

   localparam logic [CW-1:0] CNT_START = CW'(N - 1);
   localparam logic [CW-1:0] CNT_SNAP  = CW'(FRAC);
   // 2^(W-1): largest negative magnitude; positive limit is one less
   localparam logic [N-1:0]  LIM       = {{(N-W){1'b0}}, 1'b1, {(W-1){1'b0}}};
`ifdef FP_DIV_SAT_EN
   localparam logic [W-1:0]  Q_MAX     = {1'b0, {(W-1){1'b1}}};
   localparam logic [W-1:0]  Q_MIN     = {1'b1, {(W-1){1'b0}}};
`endif

   typedef enum logic [1:0] {IDLE, DIV, FIX, DONE} state_t;

   state_t          state, state_nxt;

   logic            sa, sb, d0;
   logic [W-1:0]    a_reg, b_reg;
   logic [W-1:0]    bmag;       // |b| as unsigned W bits, exact for -2^(W-1)
   logic [N-1:0]    dvd;        // dividend {|a|, FRAC zeros}, shifted out MSB first
   logic [N-1:0]    qmag;
   logic [W-1:0]    rem;        // always < |b| <= 2^(W-1)
   logic [W-1:0]    snap;       // |a| mod |b|
   logic [CW-1:0]   cnt;

   logic [W-1:0]    a_mag, b_mag;
   logic [W:0]      rem_sh;
   logic            take;
   logic [W-1:0]    rem_nxt;
   logic            neg;
   logic [W-1:0]    q_wrap;
   logic            q_ovf;
   logic [W-1:0]    r_signed;
   logic [W-1:0]    mod_res;

   // ---------------- FSM ----------------
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy_out  = 1'b1;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            busy_out = 1'b0;
            if (in_valid) state_nxt = (b_in == '0) ? FIX : DIV;
         end
         DIV:  if (cnt == '0) state_nxt = FIX;
         FIX:  state_nxt = DONE;
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // ---------------- datapath combinational ----------------
   always_comb begin
      a_mag    = a_in[W-1] ? -a_in : a_in;
      b_mag    = b_in[W-1] ? -b_in : b_in;
      rem_sh   = {rem, dvd[N-1]};
      take     = rem_sh >= {1'b0, bmag};
      rem_nxt  = take ? W'(rem_sh - {1'b0, bmag}) : rem_sh[W-1:0];
      neg      = sa ^ sb;
      // low W bits of the negated N-bit magnitude equal negating the low W bits
      q_wrap   = neg ? -qmag[W-1:0] : qmag[W-1:0];
      q_ovf    = neg ? (qmag > LIM) : (qmag >= LIM);
      r_signed = sa ? -snap : snap;
      // truncated remainder -> floored: shift into b's sign when signs differ
      mod_res  = (r_signed != '0 && neg) ? r_signed + b_reg : r_signed;
   end

   // ---------------- datapath registers ----------------
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         sa       <= 1'b0;
         sb       <= 1'b0;
         d0       <= 1'b0;
         a_reg    <= '0;
         b_reg    <= '0;
         bmag     <= '0;
         dvd      <= '0;
         qmag     <= '0;
         rem      <= '0;
         snap     <= '0;
         cnt      <= '0;
         quot_out <= '0;
         mod_out  <= '0;
         div0_out <= 1'b0;
         ovf_out  <= 1'b0;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               sa    <= a_in[W-1];
               sb    <= b_in[W-1];
               d0    <= (b_in == '0);
               a_reg <= a_in;
               b_reg <= b_in;
               bmag  <= b_mag;
               dvd   <= {a_mag, {FRAC{1'b0}}};
               qmag  <= '0;
               rem   <= '0;
               snap  <= '0;
               cnt   <= CNT_START;
            end
            DIV: begin
               rem  <= rem_nxt;
               qmag <= {qmag[N-2:0], take};
               dvd  <= {dvd[N-2:0], 1'b0};
               cnt  <= cnt - 1'b1;
               // the integer part of the dividend has been fully consumed here
               if (cnt == CNT_SNAP) snap <= rem_nxt;
            end
            FIX: begin
               div0_out <= d0;
               ovf_out  <= d0 ? 1'b0 : q_ovf;
`ifdef FP_DIV_SAT_EN
               if (d0) begin
                  quot_out <= sa ? Q_MIN : Q_MAX;
                  mod_out  <= '0;
               end else begin
                  quot_out <= q_ovf ? (neg ? Q_MIN : Q_MAX) : q_wrap;
                  mod_out  <= mod_res;
               end
`else
               if (d0) begin
                  quot_out <= '0;
                  mod_out  <= a_reg;
               end else begin
                  quot_out <= q_wrap;
                  mod_out  <= mod_res;
               end
`endif
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fp_divmod_seq.sv
// tb_fp_divmod_seq
//   Self-checking bench for fp_divmod_seq (WHOLE=16, FRAC=16). Expected results
//   come from a plain-arithmetic reference model (64-bit divide and remainder);
//   a compare process checks every cycle in which out_valid is high.
module tb_fp_divmod_seq;

   localparam int WHOLE = 16;
   localparam int FRAC  = 16;
   localparam int W     = WHOLE + FRAC;
   localparam int N     = W + FRAC;
   localparam longint MAXQ = (longint'(1) <<< (W-1)) - 1;
   localparam longint MINQ = -(longint'(1) <<< (W-1));

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] quot, modv;
   logic         div0, ovf, busy;

   always #5 clk = ~clk;

   fp_divmod_seq #(.WHOLE(WHOLE), .FRAC(FRAC)) dut (
      .clk_in   (clk),
      .rst_in   (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .a_in     (a),
      .b_in     (b),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .quot_out (quot),
      .mod_out  (modv),
      .div0_out (div0),
      .ovf_out  (ovf),
      .busy_out (busy)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference model: real-number semantics on raw integers.
   function automatic void model(input logic [W-1:0] aa, input logic [W-1:0] bb,
                                 output logic [W-1:0] q, output logic [W-1:0] m,
                                 output logic d0, output logic ov);
      longint av, bv, qt, mt;
      av = longint'($signed(aa));
      bv = longint'($signed(bb));
      if (bv == 0) begin
         d0 = 1'b1;
         ov = 1'b0;
`ifdef FP_DIV_SAT_EN
         q = (av < 0) ? W'(MINQ) : W'(MAXQ);
         m = '0;
`else
         q = '0;
         m = aa;
`endif
      end else begin
         d0 = 1'b0;
         qt = (av * (longint'(1) <<< FRAC)) / bv;   // truncates toward zero
         ov = (qt > MAXQ) || (qt < MINQ);
         q  = W'(qt);
`ifdef FP_DIV_SAT_EN
         if (ov) q = (qt < 0) ? W'(MINQ) : W'(MAXQ);
`endif
         mt = av % bv;                               // sign follows dividend
         if (mt != 0 && ((mt < 0) != (bv < 0))) mt = mt + bv;
         m  = W'(mt);
      end
   endfunction

   // expectation for the operation in flight
   logic         pending = 1'b0;
   logic         seen    = 1'b0;
   int           lat     = 0;
   int           elat    = 0;
   logic [W-1:0] eq, em;
   logic         ed0, eov;

   // compare process: every cycle with out_valid high
   always @(negedge clk) begin
      if (pending) lat++;
      if (out_valid) begin
         if (!pending) check("spurious_out_valid", out_valid, 1'b0);
         else begin
            if (!seen) begin
               check("latency", lat, elat);
               seen = 1'b1;
            end
            check("quot", quot, eq);
            check("mod", modv, em);
            check("div0", div0, ed0);
            check("ovf", ovf, eov);
            check("in_ready_in_done", in_ready, 1'b0);
         end
      end
   end

   task automatic run_op(input logic [W-1:0] aa, input logic [W-1:0] bb, input int hold);
      int t;
      model(aa, bb, eq, em, ed0, eov);
      elat = (bb == '0) ? 2 : N + 2;
      @(negedge clk);
      t = 0;
      while (!in_ready && t < 200) begin
         @(negedge clk);
         t++;
      end
      check("in_ready_idle", in_ready, 1'b1);
      a = aa;
      b = bb;
      in_valid  = 1'b1;
      out_ready = (hold == 0);
      @(posedge clk);
      pending = 1'b1;
      seen    = 1'b0;
      lat     = 0;
      #1;
      t = 0;
      while (!out_valid && t < N + 20) begin
         // operands and in_valid must be ignored while busy
         a = $urandom;
         b = $urandom;
         in_valid = 1'($urandom_range(0, 1));
         @(negedge clk);
         t++;
      end
      in_valid = 1'b0;
      check("out_valid_timeout", out_valid, 1'b1);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check("held_valid", out_valid, 1'b1);
      end
      out_ready = 1'b1;
      @(posedge clk);
      pending = 1'b0;
      #1 out_ready = 1'b0;
      @(negedge clk);
      check("valid_drop", out_valid, 1'b0);
      check("in_ready_after", in_ready, 1'b1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not terminate, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [W-1:0] q0, m0, ra, rb;
      logic         d00, ov0;
      int           hi, cls;

      // ---- reset state ----
      #12;
      check("rst_in_ready", in_ready, 1'b1);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_quot", quot, '0);
      check("rst_mod", modv, '0);
      check("rst_flags", {div0, ovf}, 2'b00);
      @(negedge clk);
      rst = 1'b0;

      // ---- pin the model with hand-computed values ----
      model(32'h00060000, 32'h00040000, q0, m0, d00, ov0);
      check("model_6_4_q", q0, 32'h00018000);
      check("model_6_4_m", m0, 32'h00020000);
      model(32'hFFFA8000, 32'h00020000, q0, m0, d00, ov0);
      check("model_m55_2_q", q0, 32'hFFFD4000);
      check("model_m55_2_m", m0, 32'h00008000);
      model(32'h00058000, 32'h00020000, q0, m0, d00, ov0);
      check("model_55_2_m", m0, 32'h00018000);
      model(32'h75300000, 32'h00008000, q0, m0, d00, ov0);
      check("model_ovf_flag", ov0, 1'b1);
`ifdef FP_DIV_SAT_EN
      check("model_ovf_q", q0, 32'h7FFFFFFF);
`else
      check("model_ovf_q", q0, 32'hEA600000);
`endif
      model(32'hFFFF0000, 32'h00000000, q0, m0, d00, ov0);
      check("model_div0_flag", d00, 1'b1);
`ifdef FP_DIV_SAT_EN
      check("model_div0_q", q0, 32'h80000000);
      check("model_div0_m", m0, 32'h00000000);
`else
      check("model_div0_q", q0, 32'h00000000);
      check("model_div0_m", m0, 32'hFFFF0000);
`endif
      model(32'h00000005, 32'h80000000, q0, m0, d00, ov0);
      check("model_bmin_m", m0, 32'h80000005);

      // ---- directed operations ----
      run_op(32'h00060000, 32'h00040000, 0);
      run_op(32'hFFFA8000, 32'h00020000, 0);
      run_op(32'h00058000, 32'h00020000, 0);
      run_op(32'h75300000, 32'h00008000, 0);
      run_op(32'hFFFF0000, 32'h00000000, 0);
      run_op(32'h00060000, 32'h00040000, 10);
      run_op(32'h80000000, 32'h80000000, 0);
      run_op(32'h00000005, 32'h80000000, 0);
      run_op(32'h80000000, 32'hFFFFFFFF, 0);
      run_op(32'h00000000, 32'hFFFE0000, 2);

      // ---- reset pulsed mid-DIV ----
      @(negedge clk);
      a = 32'h12345678;
      b = 32'h00030000;
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (20) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("abort_busy", busy, 1'b0);
      check("abort_in_ready", in_ready, 1'b1);
      #1 rst = 1'b0;
      hi = 0;
      repeat (N + 10) begin
         @(negedge clk);
         if (out_valid) hi++;
      end
      check("abort_no_valid", hi, 0);
      run_op(32'hFFFA8000, 32'h00020000, 0);

      // ---- randomized operations ----
      for (int i = 0; i < 40; i++) begin
         cls = $urandom_range(0, 4);
         ra  = $urandom;
         rb  = $urandom;
         case (cls)
            1: begin
               rb = W'($urandom_range(1, 255));
               if ($urandom_range(0, 1) == 1) rb = -rb;
            end
            2: rb = '0;
            3: if ($urandom_range(0, 1) == 1) ra = 32'h80000000; else rb = 32'h80000000;
            4: begin
               ra = W'($signed(ra) >>> $urandom_range(0, 20));
               rb = W'($signed(rb) >>> $urandom_range(8, 24));
            end
            default: ;
         endcase
         run_op(ra, rb, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0);
      end

      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
